// File: rtl/instr_fetch_buffer.sv
// ---------------------------------------------------------------------------
// instr_fetch_buffer
//
// Fetches 32-bit instruction words from a byte-wide, 256-byte instruction
// memory. Each word takes four byte reads (fetch_pc+0..+3), issued one per
// cycle. The memory answers one cycle after each request. The bytes are packed
// big-endian and the finished word goes into a 2-entry FIFO together with its
// PC. The processor side is a valid/ready stream driven from the FIFO head.
//
// A redirect pulse flushes the FIFO, the partly assembled word and any
// outstanding byte response. It then inserts one bubble cycle and restarts
// fetching at the word-aligned redirect address.
//
// Ports
//   clk          sole clock, rising edge
//   rst_n        asynchronous active-low reset
//   imem_req     byte read request (registered)
//   imem_addr    byte address of the request (registered)
//   imem_rdata   byte returned the cycle after the request
//   redirect     one-cycle flush/restart pulse
//   redirect_pc  restart address (bits [1:0] ignored)
//   inst_valid   FIFO head holds a word
//   inst_ready   consumer accepts the head word this edge
//   inst_data    head instruction word
//   inst_pc      address of inst_data
// ---------------------------------------------------------------------------
module instr_fetch_buffer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [7:0]  imem_addr,
  input  logic [7:0]  imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc
);

  localparam logic [31:0] START_PC = RESET_PC & 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_STALL = 2'd1,
    S_REDIR = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  // Request stage: the byte being requested during the current cycle.
  logic        r_req;
  logic [7:0]  r_addr;
  logic [1:0]  r_req_idx;
  logic [1:0]  r_idx;        // next byte index to issue
  logic [31:0] r_issue_pc;   // PC of the word whose bytes are being issued

  // Response stage: imem_rdata this cycle belongs to the previous request.
  logic        r_cap_vld;
  logic [1:0]  r_cap_idx;
  logic [23:0] r_asm;        // the three most recently captured bytes
  logic [31:0] r_asm_pc;     // PC of the oldest word still in assembly

  // Two-entry FIFO.
  logic [31:0] r_fifo_data [2];
  logic [31:0] r_fifo_pc   [2];
  logic        r_wptr;
  logic        r_rptr;
  logic [1:0]  r_count;
  logic [1:0]  r_inasm;      // words started but not yet pushed

  logic        w_issue;
  logic        w_start;
  logic        w_push;
  logic        w_pop;
  logic        w_room;
  logic [2:0]  w_occ;
  logic [1:0]  w_count_nxt;
  logic [1:0]  w_inasm_nxt;
  logic [31:0] w_redir_pc;
  logic [31:0] w_word;

  assign w_redir_pc = redirect_pc & 32'hFFFF_FFFC;
  assign w_word     = {r_asm, imem_rdata};
  assign w_pop      = inst_valid & inst_ready;
  assign w_push     = r_cap_vld & (r_cap_idx == 2'd3);
  // Buffered words plus words in flight must leave space for one more word.
  // Any pop on this same edge is ignored here, so the check is conservative.
  assign w_occ      = {1'b0, r_count} + {1'b0, r_inasm};
  assign w_room     = (w_occ < 3'd2);

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_start     = 1'b0;
    if (redirect) begin
      w_state_nxt = S_REDIR;
    end else begin
      case (r_state)
        S_FETCH, S_STALL: begin
          if (r_idx != 2'd0) begin
            // Once a word has started, all four of its bytes are issued.
            w_issue     = 1'b1;
            w_state_nxt = S_FETCH;
          end else if (w_room) begin
            w_issue     = 1'b1;
            w_start     = 1'b1;
            w_state_nxt = S_FETCH;
          end else begin
            w_state_nxt = S_STALL;
          end
        end
        S_REDIR: begin
          // The pipeline is empty after a flush, so there is always room.
          w_issue     = 1'b1;
          w_start     = 1'b1;
          w_state_nxt = S_FETCH;
        end
        default: w_state_nxt = S_FETCH;
      endcase
    end
  end

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)      w_count_nxt = r_count + 2'd1;
    else if (!w_push && w_pop) w_count_nxt = r_count - 2'd1;
    w_inasm_nxt = r_inasm + {1'b0, w_start} - {1'b0, w_push};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_FETCH;
      r_req          <= 1'b0;
      r_addr         <= 8'h00;
      r_req_idx      <= 2'd0;
      r_idx          <= 2'd0;
      r_issue_pc     <= START_PC;
      r_cap_vld      <= 1'b0;
      r_cap_idx      <= 2'd0;
      r_asm          <= 24'h0;
      r_asm_pc       <= START_PC;
      r_fifo_data[0] <= 32'h0;
      r_fifo_data[1] <= 32'h0;
      r_fifo_pc[0]   <= 32'h0;
      r_fifo_pc[1]   <= 32'h0;
      r_wptr         <= 1'b0;
      r_rptr         <= 1'b0;
      r_count        <= 2'd0;
      r_inasm        <= 2'd0;
    end else if (redirect) begin
      // Flush. The response to the request made this cycle is also dropped,
      // because r_cap_vld is cleared instead of being loaded from r_req.
      r_state    <= w_state_nxt;
      r_req      <= 1'b0;
      r_idx      <= 2'd0;
      r_cap_vld  <= 1'b0;
      r_issue_pc <= w_redir_pc;
      r_asm_pc   <= w_redir_pc;
      r_wptr     <= 1'b0;
      r_rptr     <= 1'b0;
      r_count    <= 2'd0;
      r_inasm    <= 2'd0;
    end else begin
      r_state   <= w_state_nxt;
      // Request stage
      r_req     <= w_issue;
      if (w_issue) begin
        r_addr    <= r_issue_pc[7:0] + {6'd0, r_idx};
        r_req_idx <= r_idx;
        r_idx     <= r_idx + 2'd1;
        if (r_idx == 2'd3) r_issue_pc <= r_issue_pc + 32'd4;
      end
      // Response stage
      r_cap_vld <= r_req;
      r_cap_idx <= r_req_idx;
      if (r_cap_vld) r_asm <= {r_asm[15:0], imem_rdata};
      // FIFO stage
      if (w_push) begin
        r_fifo_data[r_wptr] <= w_word;
        r_fifo_pc[r_wptr]   <= r_asm_pc;
        r_wptr              <= ~r_wptr;
        r_asm_pc            <= r_asm_pc + 32'd4;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      r_count <= w_count_nxt;
      r_inasm <= w_inasm_nxt;
    end
  end

  assign imem_req   = r_req;
  assign imem_addr  = r_addr;
  assign inst_valid = (r_count != 2'd0);
  assign inst_data  = r_fifo_data[r_rptr];
  assign inst_pc    = r_fifo_pc[r_rptr];

endmodule
